// File: rtl/alu_pkg.sv
// Shared ALU encodings and multiplier state type.
// Used by the sequential multiplier and its accumulator.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_INC  = 3'b100;
  localparam logic [2:0] OP_DEC  = 3'b101;
  localparam logic [2:0] LOG_AND = 3'b000;
  localparam logic [2:0] LOG_OR  = 3'b001;
  localparam logic [2:0] LOG_XOR = 3'b010;
  localparam logic [2:0] LOG_NOT = 3'b011;
  localparam logic [2:0] LOG_SHL = 3'b101;

  localparam logic MODE_ARITH = 1'b0;
  localparam logic MODE_LOGIC = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mul_state_t;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Request/response handshake plus shared ALU bus of the multiplier.
// slave = multiplier side, master = CPU/ALU side.
interface alu_mul_seq_if #(
  parameter int DWIDTH = 32
);

  logic                  req_valid;
  logic                  req_ready;
  logic [DWIDTH-1:0]     req_a;
  logic [DWIDTH-1:0]     req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [2*DWIDTH-1:0]   rsp_prod;
  logic                  alu_busy;
  logic [DWIDTH-1:0]     alu_op1;
  logic [DWIDTH-1:0]     alu_op2;
  logic [2:0]            alu_opsel;
  logic                  alu_mode;
  logic [DWIDTH-1:0]     alu_result;
  logic                  alu_c_flag;

  modport slave (
    input  req_valid, req_a, req_b,
    input  rsp_ready,
    input  alu_result, alu_c_flag,
    output req_ready, rsp_valid, rsp_prod,
    output alu_busy, alu_op1, alu_op2,
    output alu_opsel, alu_mode
  );

  modport master (
    output req_valid, req_a, req_b,
    output rsp_ready,
    output alu_result, alu_c_flag,
    input  req_ready, rsp_valid, rsp_prod,
    input  alu_busy, alu_op1, alu_op2,
    input  alu_opsel, alu_mode
  );

endinterface

// File: rtl/alu_mul_acc.sv
// Multiplicand and shifting accumulator of the shift-and-add multiplier.
// The ALU carry becomes the new top bit, so no product bit is lost.
module alu_mul_acc
  import alu_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                step,
  input  logic [DWIDTH-1:0]   a,
  input  logic [DWIDTH-1:0]   b,
  input  logic [DWIDTH-1:0]   alu_result,
  input  logic                alu_c_flag,
  output logic [DWIDTH-1:0]   acc_hi,
  output logic [DWIDTH-1:0]   add_b,
  output logic [2*DWIDTH-1:0] acc_nxt
);

  logic [DWIDTH-1:0] mcand;
  logic [DWIDTH-1:0] acc_lo;

  assign add_b   = acc_lo[0] ? mcand : '0;
  assign acc_nxt = {alu_c_flag, alu_result, acc_lo[DWIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
    end else if (load) begin
      mcand  <= a;
      acc_lo <= b;
      acc_hi <= '0;
    end else if (step) begin
      {acc_hi, acc_lo} <= acc_nxt;
    end
  end

endmodule

// File: rtl/alu_mul_seq.sv
// Sequential unsigned multiplier driving the shared ALU in ADD mode.
// One partial-product add per cycle, DWIDTH cycles per multiply.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter  int DWIDTH = 32,
  localparam int CNTW   = $clog2(DWIDTH) + 1
) (
  input logic           clk,
  input logic           rst_n,
  alu_mul_seq_if.slave  bus
);

  mul_state_t          state_q;
  mul_state_t          state_d;
  logic [CNTW-1:0]     cnt_q;
  logic [2*DWIDTH-1:0] prod_q;
  logic [DWIDTH-1:0]   acc_hi;
  logic [DWIDTH-1:0]   add_b;
  logic [2*DWIDTH-1:0] acc_nxt;
  logic                load;
  logic                step;
  logic                last;

  assign load = (state_q == IDLE) && bus.req_valid;
  assign step = (state_q == RUN);
  assign last = (cnt_q == CNTW'(DWIDTH - 1));

  alu_mul_acc #(
    .DWIDTH (DWIDTH)
  ) u_acc (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .step       (step),
    .a          (bus.req_a),
    .b          (bus.req_b),
    .alu_result (bus.alu_result),
    .alu_c_flag (bus.alu_c_flag),
    .acc_hi     (acc_hi),
    .add_b      (add_b),
    .acc_nxt    (acc_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        cnt_q <= '0;
      end else if (step) begin
        cnt_q <= cnt_q + 1'b1;
      end
      // product register only moves on the final add
      if (step && last) begin
        prod_q <= acc_nxt;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.alu_busy  = 1'b0;
    bus.alu_op1   = '0;
    bus.alu_op2   = '0;
    unique case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          state_d = RUN;
        end
      end
      RUN: begin
        bus.alu_busy = 1'b1;
        bus.alu_op1  = acc_hi;
        bus.alu_op2  = add_b;
        if (last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.alu_opsel = OP_ADD;
  assign bus.alu_mode  = MODE_ARITH;
  assign bus.rsp_prod  = prod_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq with a behavioural ALU
// and a queue-based product scoreboard.
module tb_alu_mul_seq;
  import alu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_mul_seq_if #(.DWIDTH(W)) bus ();

  alu_mul_seq #(.DWIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // behavioural 32-bit ALU
  always_comb begin
    logic [W:0] t;
    t = '0;
    if (bus.alu_mode == MODE_ARITH) begin
      case (bus.alu_opsel)
        OP_ADD:  t = {1'b0, bus.alu_op1} + {1'b0, bus.alu_op2};
        OP_SUB:  t = {1'b0, bus.alu_op1} - {1'b0, bus.alu_op2};
        OP_INC:  t = {1'b0, bus.alu_op1} + 1;
        OP_DEC:  t = {1'b0, bus.alu_op1} - 1;
        default: t = '0;
      endcase
    end else begin
      case (bus.alu_opsel)
        LOG_AND: t = {1'b0, bus.alu_op1 & bus.alu_op2};
        LOG_OR:  t = {1'b0, bus.alu_op1 | bus.alu_op2};
        LOG_XOR: t = {1'b0, bus.alu_op1 ^ bus.alu_op2};
        LOG_NOT: t = {1'b0, ~bus.alu_op1};
        LOG_SHL: t = {bus.alu_op1, 1'b0};
        default: t = '0;
      endcase
    end
    bus.alu_result = t[W-1:0];
    bus.alu_c_flag = t[W];
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // scoreboard and per-cycle compare
  logic [63:0] q[$];
  int          acc_cyc = 0;
  logic        prev_v = 1'b0;
  logic        prev_hs = 1'b0;
  logic        prev_rst = 1'b0;
  logic [63:0] prev_p = '0;

  always @(negedge clk) begin
    if (prev_rst) begin
      chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_alu_busy", 64'(bus.alu_busy), 64'd0);
      chk("rst_prod", bus.rsp_prod, 64'd0);
    end
    if (rst_n !== 1'b1) begin
      q.delete();
    end else begin
      if (bus.rsp_valid && !prev_v) begin
        chk("latency", 64'(cyc - acc_cyc), 64'd33);
        chk("rsp_expected", 64'(q.size() != 0), 64'd1);
      end
      if (bus.rsp_valid && prev_v && !prev_hs)
        chk("prod_stable", bus.rsp_prod, prev_p);
      if (bus.rsp_valid && bus.rsp_ready && q.size() != 0)
        chk("prod_model", bus.rsp_prod, q.pop_front());
      if (bus.alu_busy) begin
        chk("run_opsel", 64'(bus.alu_opsel), 64'd0);
        chk("run_mode", 64'(bus.alu_mode), 64'd0);
        chk("run_req_ready", 64'(bus.req_ready), 64'd0);
      end else begin
        chk("idle_ops", {bus.alu_op1, bus.alu_op2}, 64'd0);
      end
      if (bus.req_valid && bus.req_ready) begin
        q.push_back(64'(bus.req_a) * 64'(bus.req_b));
        acc_cyc = cyc;
      end
    end
    prev_rst = (rst_n !== 1'b1);
    prev_v   = (rst_n === 1'b1) && bus.rsp_valid;
    prev_hs  = bus.rsp_valid && bus.rsp_ready;
    prev_p   = bus.rsp_prod;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_a = a;
    bus.req_b = b;
    while (!bus.req_ready && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) chk("accept_timeout", 64'd0, 64'd1);
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!bus.rsp_valid && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) chk("rsp_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_one(input string name, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [63:0] exp);
    bus.rsp_ready = 1'b1;
    send(a, b);
    wait_valid();
    chk(name, bus.rsp_prod, exp);
    step();
  endtask

  initial begin
    bit done;
    bit hs;
    int n;
    bus.req_valid = 1'b0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    run_one("mul_3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F);
    run_one("mul_ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            64'hFFFF_FFFE_0000_0001);
    run_one("mul_zero", 32'h0, 32'h1234_5678, 64'h0);
    run_one("mul_msb", 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000);

    // backpressure in DONE
    bus.rsp_ready = 1'b0;
    send(32'd1000, 32'd1000);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
      chk("bp_prod", bus.rsp_prod, 64'd1000000);
      step();
    end
    bus.rsp_ready = 1'b1;
    step();
    chk("bp_release_ready", 64'(bus.req_ready), 64'd1);
    chk("bp_release_valid", 64'(bus.rsp_valid), 64'd0);

    // reset in the middle of RUN
    send(32'hFFFF_FFFF, 32'd3);
    repeat (16) step();
    chk("mid_busy", 64'(bus.alu_busy), 64'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_ready", 64'(bus.req_ready), 64'd1);
    chk("mid_rst_valid", 64'(bus.rsp_valid), 64'd0);
    chk("mid_rst_busy", 64'(bus.alu_busy), 64'd0);
    run_one("mul_7x9", 32'd7, 32'd9, 64'd63);

    // random operands with random response gaps
    for (int k = 0; k < 1000; k++) begin
      if ($urandom_range(3) == 0) step();
      send($urandom, $urandom);
      done = 1'b0;
      n = 0;
      while (!done && n < 300) begin
        bus.rsp_ready = ($urandom_range(1) == 1);
        hs = bus.rsp_valid && bus.rsp_ready;
        step();
        if (hs) done = 1'b1;
        n++;
      end
      if (!done) chk("rand_timeout", 64'd0, 64'd1);
    end
    bus.rsp_ready = 1'b0;
    step();
    chk("drain", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
